// File: rtl/bp_fpga_host_pkg.sv
// Shared types for the FPGA host putchar UART: BedRock io message layout,
// processor-config selector, UART TX FSM states and register offsets.
package bp_fpga_host_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_unicore_cfg = 2'd1
    } bp_params_e;

    localparam int paddr_width_gp   = 40;
    localparam int io_data_width_gp = 64;

    function automatic int bp_paddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return paddr_width_gp;
            default:          return paddr_width_gp;
        endcase
    endfunction

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_amo   = 4'd4
    } bp_bedrock_mem_type_e;

    typedef struct packed {
        bp_bedrock_mem_type_e      msg_type;
        logic [2:0]                size;
        logic [paddr_width_gp-1:0] addr;
    } bp_bedrock_io_mem_header_s;

    typedef struct packed {
        bp_bedrock_io_mem_header_s   header;
        logic [io_data_width_gp-1:0] data;
    } bp_bedrock_io_mem_msg_s;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_start = 2'd1,
        e_data  = 2'd2,
        e_stop  = 2'd3
    } uart_tx_state_e;

    localparam logic [paddr_width_gp-1:0] putchar_data_offset_gp   = 40'h00_0000_0000;
    localparam logic [paddr_width_gp-1:0] putchar_status_offset_gp = 40'h00_0000_0008;

endpackage

// File: rtl/bp_uart_tx_serializer.sv
// 8N1 UART serializer with a valid/yumi byte input; chains frames without
// an idle bit when the next byte is already waiting.
module bp_uart_tx_serializer
    import bp_fpga_host_pkg::*;
#(
    parameter int uart_clk_per_bit_p = 10416
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] data_i,
    input  logic       v_i,
    output logic       yumi_o,
    output logic       tx_o,
    output logic       busy_o
);
    localparam int cnt_w_lp = (uart_clk_per_bit_p > 1) ? $clog2(uart_clk_per_bit_p) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(uart_clk_per_bit_p - 1);

    uart_tx_state_e      state_r, state_n;
    logic [cnt_w_lp-1:0] cnt_r, cnt_n;
    logic [2:0]          idx_r, idx_n;
    logic [7:0]          shift_r, shift_n;
    logic                tx_r, tx_n;
    logic                bit_done_s;

    assign bit_done_s = (cnt_r == cnt_max_lp);
    assign tx_o       = tx_r;
    assign busy_o     = (state_r != e_idle);

    // Next-state, bit timing and line value for the following cycle.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        idx_n   = idx_r;
        shift_n = shift_r;
        yumi_o  = 1'b0;
        case (state_r)
            e_idle: begin
                if (v_i) begin
                    yumi_o  = 1'b1;
                    shift_n = data_i;
                    cnt_n   = '0;
                    state_n = e_start;
                end else begin
                    state_n = e_idle;
                end
            end
            e_start: begin
                if (bit_done_s) begin
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    state_n = e_data;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            e_data: begin
                if (bit_done_s) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift_r[7:1]};
                    idx_n   = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_n = e_stop;
                    end else begin
                        state_n = e_data;
                    end
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            e_stop: begin
                if (bit_done_s) begin
                    cnt_n = '0;
                    // A waiting byte starts immediately so frames abut.
                    if (v_i) begin
                        yumi_o  = 1'b1;
                        shift_n = data_i;
                        state_n = e_start;
                    end else begin
                        state_n = e_idle;
                    end
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            default: begin
                state_n = e_idle;
                cnt_n   = '0;
            end
        endcase
        case (state_n)
            e_start: tx_n = 1'b0;
            e_data:  tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // State register; reset parks the line high and abandons any frame.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
            shift_r <= shift_n;
            tx_r    <= tx_n;
        end
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small single-read single-write FIFO with valid/ready input and valid/yumi
// output; exposes its occupancy for status reporting.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [width_p-1:0]       data_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic [$clog2(els_p):0]   count_o
);
    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r;
    logic [ptr_w_lp-1:0] rptr_r;
    logic [ptr_w_lp:0]   count_r;
    logic                push_s;
    logic                pop_s;

    assign ready_o = (count_r != (ptr_w_lp+1)'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign count_o = count_r;
    assign push_s  = v_i & ready_o;
    assign pop_s   = yumi_i & v_o;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) wptr_r <= wptr_r + 1'b1;
            if (pop_s)  rptr_r <= rptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bp_putchar_uart_tx.sv
// BedRock io putchar device: byte writes queue into a FIFO feeding a UART
// serializer; a status register reports busy/empty/occupancy.
module bp_putchar_uart_tx
    import bp_fpga_host_pkg::*;
#(
    parameter bp_params_e                bp_params_p        = e_bp_default_cfg,
    parameter int                        uart_clk_per_bit_p = 10416,
    parameter int                        fifo_els_p         = 8,
    parameter logic [paddr_width_gp-1:0] putchar_addr_p     = 40'h00_0010_1000
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  bp_bedrock_io_mem_msg_s io_cmd_i,
    input  logic                   io_cmd_v_i,
    output logic                   io_cmd_ready_and_o,
    output bp_bedrock_io_mem_msg_s io_resp_o,
    output logic                   io_resp_v_o,
    input  logic                   io_resp_yumi_i,
    output logic                   tx_o,
    output logic                   error_o
);
    localparam int paddr_width_lp = bp_paddr_width(bp_params_p);
    localparam logic [paddr_width_gp-1:0] data_addr_lp   = putchar_addr_p + putchar_data_offset_gp;
    localparam logic [paddr_width_gp-1:0] status_addr_lp = putchar_addr_p + putchar_status_offset_gp;

    bp_bedrock_io_mem_msg_s      resp_r;
    logic                        resp_v_r;
    logic                        error_r;
    logic                        accept_s, is_wr_s, is_stat_s, bad_s;
    logic                        fifo_ready_s, fifo_v_s, ser_yumi_s, tx_busy_s;
    logic [7:0]                  fifo_data_s;
    logic [$clog2(fifo_els_p):0] fifo_count_s;
    logic [io_data_width_gp-1:0] status_s;
    logic                        unused_s;

    assign unused_s = ^io_cmd_i.data[io_data_width_gp-1:8];

    assign io_cmd_ready_and_o = reset_n_i & ~resp_v_r & fifo_ready_s;
    assign accept_s  = io_cmd_v_i & io_cmd_ready_and_o;
    assign is_wr_s   = (io_cmd_i.header.msg_type == e_bedrock_mem_uc_wr)
                     & (io_cmd_i.header.addr[paddr_width_lp-1:0] == data_addr_lp[paddr_width_lp-1:0]);
    assign is_stat_s = (io_cmd_i.header.msg_type == e_bedrock_mem_uc_rd)
                     & (io_cmd_i.header.addr[paddr_width_lp-1:0] == status_addr_lp[paddr_width_lp-1:0]);
    assign bad_s     = ~is_wr_s & ~is_stat_s;
    assign status_s  = {48'h0, 8'(fifo_count_s), 6'h00, (fifo_count_s == '0), tx_busy_s};

    assign io_resp_o   = resp_r;
    assign io_resp_v_o = resp_v_r;
    assign error_o     = error_r;

    bsg_fifo_1r1w_small #(
        .width_p (8),
        .els_p   (fifo_els_p)
    ) tx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (accept_s & is_wr_s),
        .ready_o   (fifo_ready_s),
        .data_i    (io_cmd_i.data[7:0]),
        .v_o       (fifo_v_s),
        .data_o    (fifo_data_s),
        .yumi_i    (ser_yumi_s),
        .count_o   (fifo_count_s)
    );

    bp_uart_tx_serializer #(
        .uart_clk_per_bit_p (uart_clk_per_bit_p)
    ) serializer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (fifo_data_s),
        .v_i       (fifo_v_s),
        .yumi_o    (ser_yumi_s),
        .tx_o      (tx_o),
        .busy_o    (tx_busy_s)
    );

    // Single-entry response register plus the sticky bad-access flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_r   <= '0;
            resp_v_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                resp_v_r      <= 1'b1;
                resp_r.header <= io_cmd_i.header;
                resp_r.data   <= is_stat_s ? status_s : '0;
            end else if (io_resp_yumi_i) begin
                resp_v_r <= 1'b0;
            end
            error_r <= error_r | (accept_s & bad_s);
        end
    end

endmodule

// File: tb/tb_bp_putchar_uart_tx.sv
// Randomized bench for bp_putchar_uart_tx with a frame-timeline reference
// model and a per-cycle compare process.
module tb_bp_putchar_uart_tx;
    import bp_fpga_host_pkg::*;

    localparam int P     = 4;
    localparam int ELS   = 4;
    localparam int FRAME = 10 * P;
    localparam logic [39:0] DATA_A = 40'h00_0010_1000;
    localparam logic [39:0] STAT_A = 40'h00_0010_1008;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bp_bedrock_io_mem_msg_s io_cmd_i = '0;
    bp_bedrock_io_mem_msg_s io_resp_o;
    logic io_cmd_v_i = 1'b0;
    logic io_cmd_ready_and_o, io_resp_v_o, tx_o, error_o;
    logic io_resp_yumi_i = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: frame timeline + response register image
    int   t_now = 0;
    int   last_end = 0;
    int   fst[$];
    int   fac[$];
    logic [7:0] fby[$];
    logic pend_m = 1'b0;
    logic err_m = 1'b0;
    bp_bedrock_io_mem_header_s hdr_m = '0;
    logic [63:0] data_m = 64'h0;

    bp_putchar_uart_tx #(
        .uart_clk_per_bit_p (P),
        .fifo_els_p         (ELS)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .io_cmd_i           (io_cmd_i),
        .io_cmd_v_i         (io_cmd_v_i),
        .io_cmd_ready_and_o (io_cmd_ready_and_o),
        .io_resp_o          (io_resp_o),
        .io_resp_v_o        (io_resp_v_o),
        .io_resp_yumi_i     (io_resp_yumi_i),
        .tx_o               (tx_o),
        .error_o            (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, t_now);
    endtask

    function automatic int cnt_q(input int t);
        int c = 0;
        foreach (fst[i]) if (fac[i] <= t && fst[i] > t) c++;
        return c;
    endfunction

    function automatic logic busy_at(input int t);
        foreach (fst[i]) if (t >= fst[i] && t < fst[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic tx_exp(input int t);
        logic [7:0] b;
        int idx;
        foreach (fst[i]) begin
            if (t >= fst[i] && t < fst[i] + FRAME) begin
                idx = (t - fst[i]) / P;
                b = fby[i];
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return b[idx-1];
            end
        end
        return 1'b1;
    endfunction

    // Reference model: advances one clock edge at a time.
    initial begin
        int k, s;
        logic rdy, is_wr, is_st;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                fst.delete(); fac.delete(); fby.delete();
                last_end = 0; pend_m = 1'b0; err_m = 1'b0;
            end else begin
                k = t_now + 1;
                rdy = !pend_m && (cnt_q(t_now) < ELS);
                if (io_resp_yumi_i && pend_m) pend_m = 1'b0;
                if (io_cmd_v_i && rdy) begin
                    is_wr = (io_cmd_i.header.msg_type == e_bedrock_mem_uc_wr) && (io_cmd_i.header.addr == DATA_A);
                    is_st = (io_cmd_i.header.msg_type == e_bedrock_mem_uc_rd) && (io_cmd_i.header.addr == STAT_A);
                    data_m = 64'h0;
                    if (is_st) data_m = 64'(cnt_q(t_now)) * 256 + (cnt_q(t_now) == 0 ? 2 : 0) + (busy_at(t_now) ? 1 : 0);
                    if (is_wr) begin
                        s = (k + 1 > last_end) ? k + 1 : last_end;
                        fst.push_back(s); fac.push_back(k); fby.push_back(io_cmd_i.data[7:0]);
                        last_end = s + FRAME;
                    end
                    if (!is_wr && !is_st) err_m = 1'b1;
                    hdr_m = io_cmd_i.header;
                    pend_m = 1'b1;
                end
                t_now = k;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, mid-period.
    initial begin
        forever begin
            @(negedge clk);
            chk("tx", 64'(tx_o), 64'(tx_exp(t_now)));
            chk("ready", 64'(io_cmd_ready_and_o), 64'(rst_n && !pend_m && (cnt_q(t_now) < ELS)));
            chk("resp_v", 64'(io_resp_v_o), 64'(pend_m));
            chk("error", 64'(error_o), 64'(err_m));
            if (pend_m) begin
                chk("resp_hdr", 64'(io_resp_o.header), 64'(hdr_m));
                chk("resp_data", io_resp_o.data, data_m);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_cmd(input bp_bedrock_mem_type_e ty, input logic [39:0] a, input logic [63:0] d,
                          input int ydly, input bit hold, output int acc_t, output logic [63:0] rdata);
        bp_bedrock_io_mem_msg_s m;
        m.header.msg_type = ty;
        m.header.size = 3'd3;
        m.header.addr = a;
        m.data = d;
        io_cmd_i = m;
        io_cmd_v_i = 1'b1;
        acc_t = -1;
        rdata = 64'h0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (io_cmd_ready_and_o) begin
                @(posedge clk);
                #1;
                acc_t = t_now;
                break;
            end
        end
        io_cmd_v_i = 1'b0;
        if (acc_t < 0) begin
            chk("accept_timeout", 64'(0), 64'(1));
        end else begin
            chk("resp_v_next", 64'(io_resp_v_o), 64'(1));
            chk("resp_hdr_copy", 64'(io_resp_o.header), 64'(m.header));
            rdata = io_resp_o.data;
            for (int i = 0; i < ydly; i++) begin
                if (hold) begin
                    chk("hold_ready", 64'(io_cmd_ready_and_o), 64'(0));
                    chk("hold_hdr", 64'(io_resp_o.header), 64'(m.header));
                    chk("hold_data", io_resp_o.data, 64'h0);
                end
                @(posedge clk);
                #1;
            end
            io_resp_yumi_i = 1'b1;
            @(posedge clk);
            #1;
            io_resp_yumi_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && t_now <= last_end; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, a5, a6;
        int r;
        logic [63:0] rd;
        logic [9:0] pat;
        bp_bedrock_mem_type_e ty;
        logic [39:0] ad;

        // reset, then ready from the first edge
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_first_edge", 64'(io_cmd_ready_and_o), 64'(1));

        // single byte 0x41 with known line pattern
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'h41, 0, 1'b0, acc, rd);
        pat = 10'b1010000010;
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 1 : P) @(posedge clk);
            #1;
            chk("frame_0x41", 64'(tx_o), 64'(pat[i]));
        end
        wait_idle();

        // status while 0x55 transmits with two bytes queued
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'h55, 0, 1'b0, acc, rd);
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'h66, 0, 1'b0, acc, rd);
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'h77, 0, 1'b0, acc, rd);
        do_cmd(e_bedrock_mem_uc_rd, STAT_A, 64'h0, 0, 1'b0, acc, rd);
        chk("status_0201", rd, 64'h0201);
        wait_idle();

        // fill the FIFO; last write waits for the first pop
        for (int i = 0; i < 6; i++) begin
            do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'(8'h30 + i), 0, 1'b0, acc, rd);
            if (i == 4) begin
                a5 = acc;
                chk("full_ready_low", 64'(io_cmd_ready_and_o), 64'(0));
            end
            if (i == 5) a6 = acc;
        end
        chk("accept_after_pop", 64'(a6 - a5), 64'(34));
        chk("model_span", 64'(fst[fst.size()-1] - fst[fst.size()-6]), 64'(5 * FRAME));

        // response held for 20 cycles
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'h21, 20, 1'b1, acc, rd);

        // bad access sets sticky error
        do_cmd(e_bedrock_mem_uc_rd, 40'h00_0010_2000, 64'h0, 0, 1'b0, acc, rd);
        chk("bad_zero_data", rd, 64'h0);
        chk("error_set", 64'(error_o), 64'(1));
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'h22, 0, 1'b0, acc, rd);
        chk("error_sticky", 64'(error_o), 64'(1));
        wait_idle();

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            r = $urandom_range(0, 9);
            ty = e_bedrock_mem_uc_wr;
            ad = DATA_A;
            if (r == 6 || r == 7) ty = e_bedrock_mem_uc_rd;
            if (r == 6 || r == 7) ad = STAT_A;
            if (r == 8) ad = STAT_A;
            if (r == 9) begin
                case ($urandom_range(0, 2))
                    0: ty = e_bedrock_mem_uc_rd;
                    1: ty = e_bedrock_mem_wr;
                    default: ad = {8'h00, $urandom};
                endcase
            end
            do_cmd(ty, ad, {$urandom, $urandom}, $urandom_range(0, 5), 1'b0, acc, rd);
        end
        wait_idle();

        // reset in the middle of data bit 3 of 0xAA
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'hAA, 0, 1'b0, acc, rd);
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'hBB, 0, 1'b0, a5, rd);
        for (int i = 0; i < 200 && t_now < acc + 1 + 4 * P + 1; i++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_high", 64'(tx_o), 64'(1));
        chk("rst_ready_low", 64'(io_cmd_ready_and_o), 64'(0));
        chk("rst_resp_v_low", 64'(io_resp_v_o), 64'(0));
        chk("rst_error_low", 64'(error_o), 64'(0));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        do_cmd(e_bedrock_mem_uc_rd, STAT_A, 64'h0, 0, 1'b0, acc, rd);
        chk("post_reset_status", rd, 64'h0002);
        do_cmd(e_bedrock_mem_uc_wr, DATA_A, 64'h5A, 2, 1'b0, acc, rd);
        wait_idle();
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
